// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one side of a pipeline stage register.
// The master drives valid/data/ctrl and the slave drives ready.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with handshake, flush and stall counter.
// PIPE_SKID_EN adds a one-entry skid so in_ready has no path from out_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc;
  logic              rel;

  assign rel = valid_q & out_if.ready;
  assign acc = in_if.valid & in_if.ready;

`ifdef PIPE_SKID_EN
  logic              sfull_q, sfull_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [CTRL_W-1:0] sctrl_q, sctrl_d;

  assign in_if.ready = ~reset & ~sfull_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    sfull_d = sfull_q;
    sdata_d = sdata_q;
    sctrl_d = sctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      sfull_d = 1'b0;
    end else if (rel) begin
      if (sfull_q) begin
        valid_d = 1'b1;
        data_d  = sdata_q;
        ctrl_d  = sctrl_q;
        if (acc) begin
          sdata_d = in_if.data;
          sctrl_d = in_if.ctrl;
        end else begin
          sfull_d = 1'b0;
        end
      end else if (acc) begin
        valid_d = 1'b1;
        data_d  = in_if.data;
        ctrl_d  = in_if.ctrl;
      end else begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
    end else if (acc) begin
      // Main entry stalled: the newcomer waits behind it in the skid.
      if (valid_q) begin
        sfull_d = 1'b1;
        sdata_d = in_if.data;
        sctrl_d = in_if.ctrl;
      end else begin
        valid_d = 1'b1;
        data_d  = in_if.data;
        ctrl_d  = in_if.ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sfull_q <= 1'b0;
      sdata_q <= '0;
      sctrl_q <= '0;
    end else begin
      sfull_q <= sfull_d;
      sdata_q <= sdata_d;
      sctrl_q <= sctrl_d;
    end
  end
`else
  assign in_if.ready = ~reset & (~valid_q | out_if.ready);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (acc) begin
      valid_d = 1'b1;
      data_d  = in_if.data;
      ctrl_d  = in_if.ctrl;
    end else if (rel) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (valid_q & ~out_if.ready & (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.data  = data_q;
  assign out_if.ctrl  = ctrl_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps plus random traffic vs a queue model.
// The model is a FIFO of capacity 1 (or 2 with PIPE_SKID_EN).
module tb_pipe_stage_reg;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int NW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [NW-1:0] stall_cnt;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_if(up), .out_if(dn), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] last_d;
  int            cnt;
  int            cap;
  int            tests = 0;
  int            fails = 0;

  function automatic logic [CW-1:0] ctl(input logic [DW-1:0] w);
    return CW'(w * 37 + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    if (reset) return 1'b0;
    if (cap == 2) return q.size() < 2;
    return (q.size() == 0) || dn.ready;
  endfunction

  task automatic check_outs(input string tag);
    bit v;
    v = q.size() > 0;
    chk({tag, "_valid"}, 64'(dn.valid), 64'(v));
    chk({tag, "_data"}, 64'(dn.data), 64'(last_d));
    chk({tag, "_ctrl"}, 64'(dn.ctrl), v ? 64'(q[0].c) : 64'd0);
    chk({tag, "_cnt"}, 64'(stall_cnt), 64'(cnt));
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input bit ordy, input bit fl);
    up.valid = v;
    up.data  = d;
    up.ctrl  = c;
    dn.ready = ordy;
    flush    = fl;
  endtask

  task automatic cyc(input string tag, output bit acc);
    bit rdy;
    int n;
    ent_t e;
    @(negedge clk);
    rdy = m_ready();
    chk({tag, "_in_ready"}, 64'(up.ready), 64'(rdy));
    acc = up.valid && rdy;
    n = q.size();
    e.d = up.data;
    e.c = up.ctrl;
    @(posedge clk);
    #1;
    if (n > 0 && !dn.ready && cnt < CMAX) cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (n > 0 && dn.ready) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last_d = q[0].d;
    check_outs(tag);
  endtask

  task automatic send(input string tag, input logic [DW-1:0] w,
                      input bit ordy, input bit fl, output bit acc);
    drive(1'b1, w, ctl(w), ordy, fl);
    cyc(tag, acc);
  endtask

  task automatic idle(input string tag, input int n);
    bit a;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      cyc(tag, a);
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    reset    = 1'b1;
    up.valid = 1'b1;
    up.data  = 32'hDEAD_BEEF;
    up.ctrl  = 16'hFFFF;
    #1;
    q.delete();
    last_d = '0;
    cnt    = 0;
    check_outs({tag, "_async"});
    chk({tag, "_rst_in_ready"}, 64'(up.ready), 64'd0);
    @(posedge clk);
    #1;
    check_outs({tag, "_held"});
    #2;
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    chk({tag, "_rel_in_ready"}, 64'(up.ready), 64'd1);
  endtask

  initial begin
    bit            a;
    int            nxt;
    int            guard;
    bit            hold;
    bit            v;
    logic [DW-1:0] pd;
`ifdef PIPE_SKID_EN
    cap = 2;
`else
    cap = 1;
`endif
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    q.delete();
    last_d = '0;
    cnt    = 0;

    do_reset("t1");

    for (int w = 1; w <= 8; w++) begin
      send("t2", DW'(w), 1'b1, 1'b0, a);
      chk("t2_acc", 64'(a), 64'd1);
      chk("t2_word", 64'(dn.data), 64'(w));
    end
    idle("t2_idle", 2);

    do_reset("t3r");
    for (int w = 1; w <= 3; w++) send("t3f", DW'(w), 1'b1, 1'b0, a);
    nxt = 4;
    for (int i = 0; i < 5; i++) begin
      send("t3s", DW'(nxt), 1'b0, 1'b0, a);
      if (a) nxt++;
    end
    chk("t3_hold", 64'(dn.data), 64'd3);
    chk("t3_cnt5", 64'(stall_cnt), 64'd5);
    chk("t3_in_ready", 64'(up.ready), 64'd0);
    guard = 0;
    while (nxt <= 6 && guard < 20) begin
      send("t3d", DW'(nxt), 1'b1, 1'b0, a);
      if (a) nxt++;
      guard++;
    end
    chk("t3_drain_bound", 64'(nxt), 64'd7);
    idle("t3_idle", 3);

    do_reset("t4r");
    for (int w = 5; w <= 8; w++) begin
      send("t4", DW'(w), 1'b1, w == 6, a);
      if (w == 6) begin
        chk("t4_flush_valid", 64'(dn.valid), 64'd0);
        chk("t4_flush_ctrl", 64'(dn.ctrl), 64'd0);
      end
      if (w == 7) chk("t4_w7", 64'(dn.data), 64'd7);
    end
    idle("t4_idle", 2);

    do_reset("t5r");
    send("t5f", 32'd9, 1'b1, 1'b0, a);
    for (int i = 0; i < 20; i++) send("t5s", 32'd10, 1'b0, 1'b0, a);
    chk("t5_sat", 64'(stall_cnt), 64'd15);
    idle("t5_idle", 4);

    do_reset("t6a");
    for (int w = 20; w < 23; w++) send("t6f", DW'(w), 1'b0, 1'b0, a);
    do_reset("t6b");
    idle("t6_idle", 3);
    chk("t6_no_stale", 64'(dn.valid), 64'd0);

    do_reset("rnd_r");
    hold = 1'b0;
    v    = 1'b0;
    pd   = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        v  = $urandom_range(0, 3) != 0;
        pd = $urandom;
      end
      drive(v, pd, ctl(pd), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
      cyc("rnd", a);
      hold = v && !a && !flush;
    end
    idle("rnd_idle", 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
